// File: rtl/cpu_shift_pkg.sv
// Shared definitions for the iterative shift unit.
//   - Operation encodings driven on the 'op' port by the decoder.
//   - FSM state encodings of iter_shift_unit. They are 2-bit constants rather
//     than an enum so they can be compared directly against a plain logic
//     state register.
package cpu_shift_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step (purely combinational).
// Ports:
//   op      : operation (SHIFT_SLL / SHIFT_SRL / SHIFT_SRA / SHIFT_ROR)
//   value   : current value
//   shifted : value moved by exactly one bit position according to op
module shift_step
  import cpu_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (op)
      SHIFT_SLL: shifted = {value[WIDTH-2:0], 1'b0};
      SHIFT_SRL: shifted = {1'b0, value[WIDTH-1:1]};
      // Arithmetic: the sign bit is replicated into the vacated MSB.
      SHIFT_SRA: shifted = {value[WIDTH-1], value[WIDTH-1:1]};
      // Rotate right: the bit leaving at position 0 re-enters at the MSB.
      SHIFT_ROR: shifted = {value[0], value[WIDTH-1:1]};
      default:   shifted = value;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: moves the operand one bit per clock.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   clr_n  : synchronous active-low reset, overrides everything
//   start  : request; accepted only in IDLE or DONE
//   op     : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   x      : operand
//   shamt  : shift amount 0..WIDTH-1
//   busy   : high while shifting
//   done   : one-cycle pulse, result valid
//   result : shifted value, held until the next accepted start
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// unit is in IDLE or DONE; x/op/shamt are captured at that edge and may
// change freely afterwards. busy is then high for shamt+1 cycles, followed
// by exactly one cycle of done with the final result. start seen while busy
// is ignored. Holding start high through the done cycle launches the next
// operation with no idle gap. busy and done are never high together.
module iter_shift_unit
  import cpu_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   x,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  logic [1:0]         state_q;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] count_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   step_value;
  logic               accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .value   (result_q),
    .shifted (step_value)
  );

  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= ST_IDLE;
      op_q     <= SHIFT_SLL;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            result_q <= x;
            op_q     <= op;
            count_q  <= shamt;
            state_q  <= ST_SHIFT;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // The count==0 cycle performs no step; it is what makes the
          // latency uniform (shamt+1 busy cycles) including shamt=0.
          if (count_q != '0) begin
            result_q <= step_value;
            count_q  <= count_q - SHAMT_W'(1);
          end else begin
            state_q  <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pure decodes of the state register, so no input reaches an output
  // combinationally.
  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
module tb_iter_shift_unit;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  x;
  logic [SW-1:0] shamt;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Scoreboard: expected result, accept edge and edge after which done shows.
  logic [W-1:0] exp_q[$];
  int           start_q[$];
  int           due_q[$];
  logic [W-1:0] last_res = '0;

  iter_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .op     (op),
    .x      (x),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] v,
                                             input int s);
    logic signed [W-1:0] sv;
    sv = v;
    case (o)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return sv >>> s;
      default: return (s == 0) ? v : ((v >> s) | (v << (W - s)));
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [W-1:0] xv, input logic [SW-1:0] s);
    op = o; x = xv; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(ref_shift(o, xv, int'(s)));
    start_q.push_back(cyc);
    due_q.push_back(cyc + int'(s) + 1);
    // Inputs are free to change once the request has been taken.
    op = 2'($urandom); x = $urandom; shamt = SW'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 80 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_done: got no done within 80 cycles expected done (cycle %0d)", cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_busy;
      exp_busy = (due_q.size() > 0) && (cyc >= start_q[0]) && (cyc < due_q[0]);
      chk("busy", W'(busy), W'(exp_busy));
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", W'(done), '0);
        end else begin
          chk("result", result, exp_q[0]);
          chk("latency", W'(cyc), W'(due_q[0]));
          last_res = exp_q[0];
          void'(exp_q.pop_front());
          void'(start_q.pop_front());
          void'(due_q.pop_front());
        end
      end else if (due_q.size() > 0 && cyc >= due_q[0]) begin
        chk("missing_done", W'(done), 1);
        void'(exp_q.pop_front());
        void'(start_q.pop_front());
        void'(due_q.pop_front());
      end else if (!busy) begin
        chk("result_hold", result, last_res);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clr_n = 1'b0; start = 1'b0; op = 2'b00; x = '0; shamt = '0;
    idle(2);
    @(negedge clk);
    chk("rst_result", result, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    clr_n = 1'b1;
    mon_en = 1'b1;
    idle(4);

    // Directed cases
    issue(2'b00, 32'h0000_0001, 5'd4);  wait_done(); idle(2);
    issue(2'b10, 32'h8000_0000, 5'd31); wait_done(); idle(1);
    issue(2'b01, 32'h8000_0000, 5'd31); wait_done(); idle(1);
    issue(2'b11, 32'h0000_00F1, 5'd4);  wait_done(); idle(1);
    for (int o = 0; o < 4; o++) begin
      issue(2'(o), 32'hA5C3_0F96, 5'd0); wait_done(); idle(1);
    end

    // start during SHIFT must be ignored
    issue(2'b01, 32'hDEAD_BEEF, 5'd20);
    idle(3);
    start = 1'b1; x = 32'h1234_5678; op = 2'b00; shamt = 5'd1;
    idle(1);
    start = 1'b0;
    wait_done(); idle(2);

    // back-to-back: next request presented during the done cycle
    issue(2'b11, 32'h0F0F_1234, 5'd7);  wait_done();
    issue(2'b10, 32'hF000_0001, 5'd3);  wait_done();
    issue(2'b00, 32'hFFFF_FFFF, 5'd31); wait_done(); idle(2);

    // reset in the middle of a shamt=10 operation
    issue(2'b00, 32'h0000_00FF, 5'd10);
    idle(2);
    clr_n = 1'b0;
    idle(1);
    exp_q.delete(); start_q.delete(); due_q.delete();
    last_res = '0;
    chk("midrst_result", result, '0);
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_done", W'(done), '0);
    clr_n = 1'b1;
    idle(15);
    issue(2'b00, 32'h0000_0003, 5'd1); wait_done(); idle(2);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, SW'($urandom_range(0, 31)));
      wait_done();
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(5);

    chk("queue_drained", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
